// File: rtl/mmu_req_stage_pkg.sv
// Shared types and constants for the MMU request stage.
// Covers the address type, size encoding, kseg nibbles and the buffered entry.
package mmu_req_stage_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam logic [3:0] KSEG0_LO  = 4'h8;
    localparam logic [3:0] KSEG0_HI  = 4'h9;
    localparam logic [3:0] KSEG1_LO  = 4'hA;
    localparam logic [3:0] KSEG1_HI  = 4'hB;
    localparam logic [2:0] KSEG1_SEG = 3'b101;

    typedef struct packed {
        addr_t      paddr;
        data_t      wdata;
        logic       uncached;
        size_e      size;
        logic       write;
        logic [3:0] strobe;
    } entry_t;

    function automatic logic misaligned(size_e sz, addr_t va);
        case (sz)
            SIZE_HALF: return va[0];
            SIZE_WORD: return |va[1:0];
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mmu_req_stage_xlate.sv
// Direct-mapped kseg0/kseg1 translator: strips the segment bits
// and flags the kseg1 window as uncached.
module mmu_req_stage_xlate
    import mmu_req_stage_pkg::*;
(
    input  addr_t vaddr_i,
    output addr_t paddr_o,
    output logic  uncached_o
);

    always_comb begin
        paddr_o = vaddr_i;
        case (vaddr_i[31:28])
            KSEG0_LO, KSEG1_LO: paddr_o[31:28] = 4'h0;
            KSEG0_HI, KSEG1_HI: paddr_o[31:28] = 4'h1;
            default: ;
        endcase
    end

    assign uncached_o = (vaddr_i[31:29] == KSEG1_SEG);

endmodule

// File: rtl/mmu_req_stage.sv
// MMU request stage: translates requests and queues them in a small FIFO.
// Define MMU_ALIGN_CHECK_EN to reject misaligned requests via err_*.
module mmu_req_stage
    import mmu_req_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_vaddr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_write,
    input  logic [3:0]  req_strobe,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_paddr,
    output logic [31:0] out_wdata,
    output logic        out_uncached,
    output logic [1:0]  out_size,
    output logic        out_write,
    output logic [3:0]  out_strobe,
    output logic        err_valid,
    output logic        err_store,
    output logic [31:0] err_vaddr
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [OW-1:0] occ_q, occ_d;

    entry_t mem_q [DEPTH];
    entry_t head;
    entry_t new_entry;

    addr_t xl_paddr;
    logic  xl_uncached;
    logic  accept, misalign, push, pop;

    mmu_req_stage_xlate u_xlate (
        .vaddr_i    (req_vaddr),
        .paddr_o    (xl_paddr),
        .uncached_o (xl_uncached)
    );

    assign req_ready = (occ_q < OW'(DEPTH));
    assign out_valid = (occ_q != '0);
    assign accept    = req_valid && req_ready && !flush;

`ifdef MMU_ALIGN_CHECK_EN
    assign misalign = misaligned(size_e'(req_size), req_vaddr);
`else
    assign misalign = 1'b0;
`endif

    assign push = accept && !misalign;
    assign pop  = out_valid && out_ready;

    always_comb begin
        new_entry          = '0;
        new_entry.paddr    = xl_paddr;
        new_entry.wdata    = req_wdata;
        new_entry.uncached = xl_uncached;
        new_entry.size     = size_e'(req_size);
        new_entry.write    = req_write;
        new_entry.strobe   = req_strobe;
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            occ_d = '0;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            occ_d = occ_q + OW'(push) - OW'(pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    // Payload storage needs no reset; occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= new_entry;
    end

    assign head         = mem_q[rd_q];
    assign out_paddr    = head.paddr;
    assign out_wdata    = head.wdata;
    assign out_uncached = head.uncached;
    assign out_size     = head.size;
    assign out_write    = head.write;
    assign out_strobe   = head.strobe;

`ifdef MMU_ALIGN_CHECK_EN
    logic        err_valid_q;
    logic        err_store_q;
    logic [31:0] err_vaddr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_valid_q <= 1'b0;
            err_store_q <= 1'b0;
            err_vaddr_q <= '0;
        end else begin
            err_valid_q <= accept && misalign;
            if (accept && misalign) begin
                err_store_q <= req_write;
                err_vaddr_q <= req_vaddr;
            end
        end
    end

    assign err_valid = err_valid_q;
    assign err_store = err_store_q;
    assign err_vaddr = err_vaddr_q;
`else
    assign err_valid = 1'b0;
    assign err_store = 1'b0;
    assign err_vaddr = '0;
`endif

endmodule

// File: tb/tb_mmu_req_stage.sv
// Bench for mmu_req_stage: queue-based reference model plus directed
// vectors with literal expectations for translation, stall, flush and reset.
module tb_mmu_req_stage;

    localparam int DEPTH = 2;

`ifdef MMU_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_write;
    logic [3:0]  req_strobe;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_paddr;
    logic [31:0] out_wdata;
    logic        out_uncached;
    logic [1:0]  out_size;
    logic        out_write;
    logic [3:0]  out_strobe;
    logic        err_valid;
    logic        err_store;
    logic [31:0] err_vaddr;

    mmu_req_stage #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_vaddr    (req_vaddr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_write    (req_write),
        .req_strobe   (req_strobe),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_paddr    (out_paddr),
        .out_wdata    (out_wdata),
        .out_uncached (out_uncached),
        .out_size     (out_size),
        .out_write    (out_write),
        .out_strobe   (out_strobe),
        .err_valid    (err_valid),
        .err_store    (err_store),
        .err_vaddr    (err_vaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] paddr;
        logic [31:0] wdata;
        logic        unc;
        logic [1:0]  size;
        logic        wr;
        logic [3:0]  strb;
    } exp_t;

    exp_t        q[$];
    logic        e_err_v;
    logic        e_err_s;
    logic [31:0] e_err_a;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_pa(input logic [31:0] va);
        int nib;
        logic [31:0] pa;
        nib = int'(va[31:28]);
        if (nib >= 8 && nib <= 11) nib = nib % 2;
        pa = va;
        pa[31:28] = nib[3:0];
        return pa;
    endfunction

    function automatic logic model_mis(input logic [1:0] sz,
                                       input logic [31:0] va);
        return (sz == 2'd1 && va[0]) || (sz == 2'd2 && va[1:0] != 2'b00);
    endfunction

    // Reference model: advances on each clock edge from the bench inputs.
    always @(posedge clk or negedge resetn) begin : mdl
        bit   rdy, acc, mis, pp;
        exp_t e;
        if (!resetn) begin
            q.delete();
            e_err_v = 1'b0;
            e_err_s = 1'b0;
            e_err_a = '0;
        end else begin
            rdy = (q.size() < DEPTH);
            pp  = (q.size() > 0) && out_ready;
            acc = req_valid && rdy && !flush;
            mis = ALIGN_EN && model_mis(req_size, req_vaddr);
            e_err_v = acc && mis;
            if (acc && mis) begin
                e_err_s = req_write;
                e_err_a = req_vaddr;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (pp) void'(q.pop_front());
                if (acc && !mis) begin
                    e.paddr = model_pa(req_vaddr);
                    e.wdata = req_wdata;
                    e.unc   = (req_vaddr[31:29] == 3'b101);
                    e.size  = req_size;
                    e.wr    = req_write;
                    e.strb  = req_strobe;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        chk("req_ready", {31'b0, req_ready}, {31'b0, q.size() < DEPTH});
        if (q.size() > 0) begin
            chk("out_paddr", out_paddr, q[0].paddr);
            chk("out_wdata", out_wdata, q[0].wdata);
            chk("out_uncached", {31'b0, out_uncached}, {31'b0, q[0].unc});
            chk("out_size", {30'b0, out_size}, {30'b0, q[0].size});
            chk("out_write", {31'b0, out_write}, {31'b0, q[0].wr});
            chk("out_strobe", {28'b0, out_strobe}, {28'b0, q[0].strb});
        end
        chk("err_valid", {31'b0, err_valid}, {31'b0, e_err_v});
        chk("err_store", {31'b0, err_store}, {31'b0, e_err_s});
        chk("err_vaddr", err_vaddr, e_err_a);
    end

    task automatic drive(input logic [31:0] va, input logic [31:0] wd,
                         input logic [1:0] sz, input logic wr,
                         input logic [3:0] st);
        req_valid  = 1'b1;
        req_vaddr  = va;
        req_wdata  = wd;
        req_size   = sz;
        req_write  = wr;
        req_strobe = st;
    endtask

    task automatic wait_accept();
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            acc = req_ready;
            @(negedge clk);
            if (acc) break;
        end
        req_valid = 1'b0;
        chk("accept_timeout", {31'b0, acc}, 32'd1);
    endtask

    task automatic send(input logic [31:0] va, input logic [31:0] wd,
                        input logic [1:0] sz, input logic wr,
                        input logic [3:0] st);
        drive(va, wd, sz, wr, st);
        wait_accept();
    endtask

    initial begin
        resetn     = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_vaddr  = '0;
        req_wdata  = '0;
        req_size   = 2'd0;
        req_write  = 1'b0;
        req_strobe = 4'h0;
        out_ready  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_err_valid", {31'b0, err_valid}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // kseg0 high half, then kseg1 and kuseg back to back
        out_ready = 1'b1;
        send(32'h9FC0_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 4'hF);
        chk("k0_valid", {31'b0, out_valid}, 32'd1);
        chk("k0_paddr", out_paddr, 32'h1FC0_0010);
        chk("k0_unc", {31'b0, out_uncached}, 32'd0);
        send(32'hBFD0_0004, 32'h1122_3344, 2'd2, 1'b1, 4'hF);
        chk("k1_paddr", out_paddr, 32'h1FD0_0004);
        chk("k1_unc", {31'b0, out_uncached}, 32'd1);
        send(32'h0040_0000, 32'h0000_00AB, 2'd0, 1'b1, 4'h1);
        chk("ku_paddr", out_paddr, 32'h0040_0000);
        chk("ku_unc", {31'b0, out_uncached}, 32'd0);
        chk("ku_strobe", {28'b0, out_strobe}, 32'h1);
        @(negedge clk);
        chk("drained", {31'b0, out_valid}, 32'd0);

        // fill to DEPTH with the sink stalled, third request waits
        out_ready = 1'b0;
        send(32'h8000_1000, 32'hA, 2'd2, 1'b0, 4'hF);
        send(32'h8000_2000, 32'hB, 2'd2, 1'b0, 4'hF);
        drive(32'h8000_3000, 32'hC, 2'd1, 1'b1, 4'h3);
        chk("full_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("full_ready2", {31'b0, req_ready}, 32'd0);
        chk("full_head", out_paddr, 32'h0000_1000);
        out_ready = 1'b1;
        wait_accept();
        chk("order_head", out_paddr, 32'h0000_3000);
        send(32'h0000_0100, 32'hD, 2'd2, 1'b0, 4'hF);
        send(32'h0000_0200, 32'hE, 2'd2, 1'b0, 4'hF);
        send(32'h0000_0300, 32'hF, 2'd2, 1'b0, 4'hF);
        for (int i = 0; i < 20; i++) begin
            if (!out_valid) break;
            @(negedge clk);
        end
        chk("drain_timeout", {31'b0, out_valid}, 32'd0);

        // flush with one entry held and a request arriving
        out_ready = 1'b0;
        send(32'h0000_4000, 32'h4, 2'd2, 1'b0, 4'hF);
        drive(32'h0000_5000, 32'h5, 2'd2, 1'b0, 4'hF);
        flush = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("flush_dropped", {31'b0, out_valid}, 32'd0);

        // reset while two entries are held
        send(32'h0000_6000, 32'h6, 2'd2, 1'b0, 4'hF);
        send(32'h0000_7000, 32'h7, 2'd2, 1'b0, 4'hF);
        chk("pre_rst_ready", {31'b0, req_ready}, 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        send(32'hA000_0040, 32'h8, 2'd2, 1'b0, 4'hF);
        chk("post_rst_paddr", out_paddr, 32'h0000_0040);
        chk("post_rst_unc", {31'b0, out_uncached}, 32'd1);
        @(negedge clk);

        // misaligned word store
        send(32'h8000_0002, 32'h9, 2'd2, 1'b1, 4'hF);
`ifdef MMU_ALIGN_CHECK_EN
        chk("mis_err_valid", {31'b0, err_valid}, 32'd1);
        chk("mis_err_store", {31'b0, err_store}, 32'd1);
        chk("mis_err_vaddr", err_vaddr, 32'h8000_0002);
        chk("mis_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("mis_err_clear", {31'b0, err_valid}, 32'd0);
`else
        chk("mis_out_valid", {31'b0, out_valid}, 32'd1);
        chk("mis_paddr", out_paddr, 32'h0000_0002);
        chk("mis_err_valid", {31'b0, err_valid}, 32'd0);
        @(negedge clk);
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
